seq_detect_sched: RTL and testbench
===================================

SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of serial input channels.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each per-channel match counter.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scheduler enable; when low, no grants are issued.
REQ-006 in_valid  input  N_CH  per-channel bit available.
REQ-007 in_bit  input  N_CH  per-channel serial data bit.
REQ-008 in_ready  output  N_CH  one-hot grant; combinational from en, in_valid and the priority pointer.
REQ-009 det_valid  output  1  registered; high for one cycle after each accepted bit.
REQ-010 det_ch  output  log2(N_CH)  registered; channel index of the bit reported by det_valid.
REQ-011 det_out  output  1  registered; 1 when that channel's updated state is C.
REQ-012 clr_cnt  input  1  synchronous clear of the counter selected by rd_sel.
REQ-013 rd_sel  input  log2(N_CH)  counter readout select.
REQ-014 cnt_out  output  CNT_W  combinational readout of the counter[rd_sel].

Function
REQ-015 A transfer on channel i SHALL occur in a cycle when in_valid[i] and in_ready[i] are both high; at most one transfer SHALL occur per cycle.
REQ-016 in_ready SHALL be all-zero when en=0 or in_valid=0.
REQ-017 Otherwise in_ready SHALL grant the first valid channel found by searching upward (mod N_CH) from ptr+1.
REQ-018 After each transfer, ptr SHALL take the granted index; ptr SHALL otherwise hold.
REQ-019 Each channel SHALL hold a private 2-bit state: A=00, B=01, C=10.
REQ-020 State transitions:
- A: bit 1 -> B, else stay A.
- B: bit 0 -> C, else stay B.
- C: bit 1 -> A, else stay C.
- Encoding 11 -> A.
REQ-021 Only the granted channel's state SHALL update; every other channel's state SHALL hold.
REQ-022 The cycle after a transfer on channel i, the block SHALL drive det_valid=1, det_ch=i and det_out=(new state==C), giving one-cycle latency.
REQ-023 det_valid SHALL be 0 in every cycle that does not follow a transfer.
REQ-024 A channel's counter SHALL increment by 1 on each B->C transition of that channel, and SHALL saturate at 2^CNT_W-1.
REQ-025 clr_cnt SHALL zero counter[rd_sel] on the next edge.
REQ-026 When clr_cnt targets a channel that increments in the same cycle, the clear SHALL win and the counter SHALL read 0.
REQ-027 Deasserting en SHALL not alter states, counters or ptr.
REQ-028 A det_valid pending from the previous cycle SHALL still be emitted after en is deasserted.

Reset
REQ-029 While RST=0, the block SHALL force all channel states to A, all counters to 0, ptr to N_CH-1 (channel 0 highest priority first), det_valid to 0, det_ch to 0 and det_out to 0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight det_valid immediately.
REQ-031 The first grant after RST rises SHALL go to the lowest-indexed valid channel.

Structure
REQ-032 A shared package SHALL hold the state encodings (A, B, C) and the default values of N_CH and CNT_W.
REQ-033 The next-state function SHALL be a combinational sub-module named seq_step (inputs: state, bit; outputs: next state, enter_c flag), instantiated once on the granted channel's context.
REQ-034 The channel contexts SHALL be flat register arrays; no memory macro SHALL be used.

Verification
REQ-035 Reset, then channel 0 alone, bits 1,0: det_out 0 then 1; counter0=1; det_ch=0 both times.
REQ-036 in_valid=4'b1111 held for 8 cycles: grants 0,1,2,3,0,1,2,3, and each in_ready is one-hot.
REQ-037 Channel 2 fed 1,0 with channel 1 fed 1,1 interleaved: only counter2=1; channel 1's state is B; contexts are independent.
REQ-038 Channel 3 fed 256 repetitions of 1,0,1: counter3=255 (saturated).
REQ-039 clr_cnt=1 with rd_sel=3 in the same cycle as a B->C on channel 3: counter3 reads 0.
REQ-040 RST pulsed low between a grant and its det_valid: det_valid stays 0, all states read A, and the next grant goes to channel 0.

Source files
------------

// File: rtl/seq_detect_sched_pkg.sv
// rtl/seq_detect_sched_pkg.sv - shared encodings and defaults for the multi-channel sequence detector
package seq_detect_sched_pkg;

   typedef enum logic [1:0] {
      ST_A = 2'b00,
      ST_B = 2'b01,
      ST_C = 2'b10
   } state_e;

   localparam int N_CH_DEF  = 4;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/seq_detect_sched_seq_step.sv
// rtl/seq_detect_sched_seq_step.sv - per-bit next-state function of one channel context
module seq_step
   import seq_detect_sched_pkg::*;
(
   input  logic [1:0] state_i,
   input  logic       bit_i,
   output logic [1:0] state_o,
   output logic       enter_c_o
);

   // Next state and B->C entry flag; the unused 11 encoding recovers to A
   always_comb begin
      state_o   = ST_A;
      enter_c_o = 1'b0;
      case (state_i)
         ST_A: state_o = bit_i ? ST_B : ST_A;
         ST_B: begin
            state_o   = bit_i ? ST_B : ST_C;
            enter_c_o = ~bit_i;
         end
         ST_C: state_o = bit_i ? ST_A : ST_C;
         default: state_o = ST_A;
      endcase
   end

endmodule

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduled sequence detector over N_CH serial channels
module seq_detect_sched
   import seq_detect_sched_pkg::*;
#(
   parameter  int N_CH  = N_CH_DEF,
   parameter  int CNT_W = CNT_W_DEF,
   localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic [N_CH-1:0]  in_valid,
   input  logic [N_CH-1:0]  in_bit,
   output logic [N_CH-1:0]  in_ready,
   output logic             det_valid,
   output logic [IW-1:0]    det_ch,
   output logic             det_out,
   input  logic             clr_cnt,
   input  logic [IW-1:0]    rd_sel,
   output logic [CNT_W-1:0] cnt_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [IW-1:0]    ptr_q, ptr_d;
   logic [1:0]       st_q  [N_CH];
   logic [1:0]       st_d  [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic             det_valid_q, det_valid_d;
   logic [IW-1:0]    det_ch_q, det_ch_d;
   logic             det_out_q, det_out_d;

   logic             xfer;
   logic [IW-1:0]    gnt_idx;
   logic [1:0]       step_st;
   logic             step_enter_c;

   // Grant the first valid channel searching upward from ptr+1, wrapping mod N_CH
   always_comb begin
      xfer     = 1'b0;
      gnt_idx  = '0;
      in_ready = '0;
      if (en) begin
         for (int k = 1; k <= N_CH; k++) begin
            if (!xfer && in_valid[(int'(ptr_q) + k) % N_CH]) begin
               xfer    = 1'b1;
               gnt_idx = IW'((int'(ptr_q) + k) % N_CH);
            end
         end
      end
      if (xfer) in_ready[gnt_idx] = 1'b1;
   end

   seq_step u_step (
      .state_i   (st_q[gnt_idx]),
      .bit_i     (in_bit[gnt_idx]),
      .state_o   (step_st),
      .enter_c_o (step_enter_c)
   );

   // Update only the granted context; a clear on the same counter overrides its increment
   always_comb begin
      ptr_d       = xfer ? gnt_idx : ptr_q;
      det_valid_d = xfer;
      det_ch_d    = xfer ? gnt_idx : det_ch_q;
      det_out_d   = xfer ? (step_st == ST_C) : det_out_q;
      for (int i = 0; i < N_CH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         if (xfer && (gnt_idx == IW'(i))) begin
            st_d[i] = step_st;
            if (step_enter_c && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + 1'b1;
         end
         if (clr_cnt && (rd_sel == IW'(i))) cnt_d[i] = '0;
      end
   end

   // State registers; reset parks ptr on the last channel so channel 0 is searched first
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr_q       <= IW'(N_CH - 1);
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
         det_out_q   <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= ST_A;
            cnt_q[i] <= '0;
         end
      end else begin
         ptr_q       <= ptr_d;
         det_valid_q <= det_valid_d;
         det_ch_q    <= det_ch_d;
         det_out_q   <= det_out_d;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign det_valid = det_valid_q;
   assign det_ch    = det_ch_q;
   assign det_out   = det_out_q;
   assign cnt_out   = cnt_q[rd_sel];

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - scoreboard bench for seq_detect_sched
module tb_seq_detect_sched;

   logic       CLK;
   logic       RST;
   logic       en;
   logic [3:0] in_valid;
   logic [3:0] in_bit;
   logic [3:0] in_ready;
   logic       det_valid;
   logic [1:0] det_ch;
   logic       det_out;
   logic       clr_cnt;
   logic [1:0] rd_sel;
   logic [7:0] cnt_out;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q [$];
   logic [1:0] m_st [4];

   seq_detect_sched #(.N_CH(4), .CNT_W(8)) dut (
      .CLK(CLK), .RST(RST), .en(en), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .det_valid(det_valid), .det_ch(det_ch), .det_out(det_out),
      .clr_cnt(clr_cnt), .rd_sel(rd_sel), .cnt_out(cnt_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [1:0] nxt(input logic [1:0] s, input logic b);
      case (s)
         2'b00:   return b ? 2'b01 : 2'b00;
         2'b01:   return b ? 2'b01 : 2'b10;
         2'b10:   return b ? 2'b00 : 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_st[i] = 2'b00;
   endtask

   // One cycle of stimulus: check the grant, queue the expected report, advance past the edge
   task automatic step(input logic [3:0] v, input logic [3:0] b, input logic e,
                       input logic [3:0] exp_gnt, input logic clr, input logic [1:0] sel);
      logic [1:0] ch;
      logic [1:0] ns;
      in_valid = v; in_bit = b; en = e; clr_cnt = clr; rd_sel = sel;
      @(negedge CLK);
      chk("in_ready", in_ready, exp_gnt);
      if (exp_gnt != 4'b0000) begin
         ch = 2'd0;
         for (int i = 0; i < 4; i++) if (exp_gnt[i]) ch = 2'(i);
         ns = nxt(m_st[ch], b[ch]);
         exp_q.push_back({ch, ns == 2'b10});
         m_st[ch] = ns;
      end
      @(posedge CLK); #1;
      in_valid = 4'b0000; clr_cnt = 1'b0; en = 1'b1;
   endtask

   task automatic rd(input logic [1:0] sel, input logic [7:0] exp, input string nm);
      rd_sel = sel;
      @(negedge CLK);
      chk(nm, cnt_out, exp);
      @(posedge CLK); #1;
   endtask

   // Monitor: every reported detection must match the oldest queued expectation
   always @(negedge CLK) begin
      if (RST && det_valid) begin
         if (exp_q.size() == 0) begin
            chk("det_valid_unexpected", det_valid, 1'b0);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            chk("det_ch", det_ch, e[2:1]);
            chk("det_out", det_out, e[0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      RST = 1'b0; en = 1'b0; in_valid = '0; in_bit = '0; clr_cnt = 1'b0; rd_sel = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_det_valid", det_valid, 1'b0);
      chk("reset_det_ch", det_ch, 2'd0);
      chk("reset_det_out", det_out, 1'b0);
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i); #1;
         chk("reset_cnt", cnt_out, 8'd0);
      end
      @(posedge CLK); #1;
      RST = 1'b1; en = 1'b1;

      // Channel 0 alone: 1 then 0 reaches C
      step(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
      step(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);
      rd(2'd0, 8'd1, "cnt0_after_10");

      // Park ptr on channel 3, then round-robin over all four
      step(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd0);
      for (int r = 0; r < 8; r++)
         step(4'b1111, 4'b0000, 1'b1, 4'b0001 << (r % 4), 1'b0, 2'd0);
      // en low: no grant, pending report still emitted, ptr held
      step(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
      step(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);

      // Interleaved channels 2 (1,0) and 1 (1,1)
      step(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0);
      step(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
      step(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0);
      step(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
      rd(2'd2, 8'd1, "cnt2_interleave");
      rd(2'd1, 8'd0, "cnt1_interleave");
      rd(2'd3, 8'd0, "cnt3_untouched");
      step(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);
      rd(2'd1, 8'd1, "cnt1_after_b_to_c");
      rd(2'd0, 8'd1, "cnt0_held");

      // Saturation on channel 3
      for (int r = 0; r < 256; r++) begin
         step(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0);
         step(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd0);
         step(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0);
      end
      rd(2'd3, 8'd255, "cnt3_saturated");
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3);
      rd(2'd3, 8'd0, "cnt3_cleared");

      // Clear colliding with an increment on channel 3
      step(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0);
      step(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd0);
      step(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0);
      rd(2'd3, 8'd1, "cnt3_before_collision");
      step(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0);
      step(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3);
      rd(2'd3, 8'd0, "cnt3_clear_wins");

      // Reset between a grant and its report
      repeat (3) @(posedge CLK);
      #1;
      in_valid = 4'b0010; in_bit = 4'b0010; en = 1'b1;
      @(negedge CLK);
      chk("in_ready_pre_reset", in_ready, 4'b0010);
      @(posedge CLK); #1;
      in_valid = 4'b0000;
      RST = 1'b0;
      model_reset();
      #1;
      chk("det_valid_reset_flush", det_valid, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b1;
      for (int r = 0; r < 4; r++)
         step(4'b1111, 4'b0000, 1'b1, 4'b0001 << r, 1'b0, 2'd0);
      rd(2'd1, 8'd0, "cnt1_after_reset");

      repeat (2) @(posedge CLK);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
